// File: rtl/sdram_arbiter.sv
// Two-port round-robin arbiter in front of an SDRAM controller; one transaction in flight at a time.
// Grant one cycle after a request seen in IDLE; a stalled transaction is aborted after TMO cycles.
module sdram_arbiter #(
  parameter int ADDR_W = 22,
  parameter int TMO    = 1000
) (
  input  logic              clk_100m,
  input  logic              rst,
  input  logic [1:0]        m_req,
  input  logic [1:0]        m_wr,
  input  logic [ADDR_W-1:0] m_addr0,
  input  logic [ADDR_W-1:0] m_addr1,
  input  logic [8:0]        m_bytes0,
  input  logic [8:0]        m_bytes1,
  output logic [1:0]        m_gnt,
  output logic [1:0]        m_done,
  output logic [1:0]        m_err,
  input  logic              sdram_init_done,
  input  logic              sdram_rd_ack,
  input  logic              sdram_wr_ack,
  output logic              sdram_rd_req,
  output logic              sdram_wr_req,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [8:0]        sdwr_bytes,
  output logic [8:0]        sdrd_bytes,
  output logic              arb_busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, XFER, DONE} state_t;

  localparam logic [15:0] TMO_C = 16'(TMO);

  state_t            state_q, state_d;
  logic              last_q, last_d;
  logic              wr_q, wr_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        done_q, done_d;
  logic [1:0]        err_q, err_d;
  logic              rd_req_q, rd_req_d;
  logic              wr_req_q, wr_req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [8:0]        wrb_q, wrb_d;
  logic [8:0]        rdb_q, rdb_d;
  logic              busy_q, busy_d;

  logic              win_c;
  logic              wr_sel_c;
  logic [8:0]        bytes_sel_c;
  logic              ack_c;
  logic [15:0]       cnt_inc_c;
  logic              tmo_hit_c;

  always_comb begin
    win_c       = (m_req == 2'b11) ? ~last_q : m_req[1];
    wr_sel_c    = m_wr[win_c];
    bytes_sel_c = win_c ? m_bytes1 : m_bytes0;
    // only the ack matching the latched direction is ever looked at
    ack_c       = wr_q ? sdram_wr_ack : sdram_rd_ack;
    cnt_inc_c   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    tmo_hit_c   = (cnt_inc_c >= TMO_C);
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    wr_d     = wr_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    done_d   = 2'b00;
    err_d    = 2'b00;
    rd_req_d = rd_req_q;
    wr_req_d = wr_req_q;
    addr_d   = addr_q;
    wrb_d    = wrb_q;
    rdb_d    = rdb_q;

    case (state_q)
      IDLE: begin
        if (sdram_init_done && (m_req != 2'b00)) begin
          state_d  = ISSUE;
          last_d   = win_c;
          wr_d     = wr_sel_c;
          cnt_d    = 16'd0;
          gnt_d    = win_c ? 2'b10 : 2'b01;
          rd_req_d = ~wr_sel_c;
          wr_req_d = wr_sel_c;
          addr_d   = win_c ? m_addr1 : m_addr0;
          wrb_d    = wr_sel_c ? bytes_sel_c : 9'd0;
          rdb_d    = wr_sel_c ? 9'd0 : bytes_sel_c;
        end
      end
      ISSUE, XFER: begin
        cnt_d = cnt_inc_c;
        // timeout wins over any ack seen on the same edge
        if (tmo_hit_c) begin
          state_d  = IDLE;
          err_d    = gnt_q;
          gnt_d    = 2'b00;
          rd_req_d = 1'b0;
          wr_req_d = 1'b0;
        end else if (state_q == ISSUE) begin
          if (ack_c) begin
            state_d  = XFER;
            rd_req_d = 1'b0;
            wr_req_d = 1'b0;
          end
        end else if (!ack_c) begin
          state_d = DONE;
          done_d  = gnt_q;
          gnt_d   = 2'b00;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_100m or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      wr_q     <= 1'b0;
      cnt_q    <= 16'd0;
      gnt_q    <= 2'b00;
      done_q   <= 2'b00;
      err_q    <= 2'b00;
      rd_req_q <= 1'b0;
      wr_req_q <= 1'b0;
      addr_q   <= '0;
      wrb_q    <= 9'd0;
      rdb_q    <= 9'd0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      wr_q     <= wr_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rd_req_q <= rd_req_d;
      wr_req_q <= wr_req_d;
      addr_q   <= addr_d;
      wrb_q    <= wrb_d;
      rdb_q    <= rdb_d;
      busy_q   <= busy_d;
    end
  end

  assign m_gnt        = gnt_q;
  assign m_done       = done_q;
  assign m_err        = err_q;
  assign sdram_rd_req = rd_req_q;
  assign sdram_wr_req = wr_req_q;
  assign sdram_addr   = addr_q;
  assign sdwr_bytes   = wrb_q;
  assign sdrd_bytes   = rdb_q;
  assign arb_busy     = busy_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Randomized transaction-level bench for sdram_arbiter with a round-robin / timing reference model.
module tb_sdram_arbiter;

  localparam int ADDR_W = 22;
  localparam int TMO    = 20;

  logic              clk_100m = 1'b0;
  logic              rst;
  logic [1:0]        m_req;
  logic [1:0]        m_wr;
  logic [ADDR_W-1:0] m_addr0, m_addr1;
  logic [8:0]        m_bytes0, m_bytes1;
  logic [1:0]        m_gnt, m_done, m_err;
  logic              sdram_init_done, sdram_rd_ack, sdram_wr_ack;
  logic              sdram_rd_req, sdram_wr_req;
  logic [ADDR_W-1:0] sdram_addr;
  logic [8:0]        sdwr_bytes, sdrd_bytes;
  logic              arb_busy;

  int n_cmp = 0;
  int n_err = 0;
  bit last_m = 1'b1;

  sdram_arbiter #(.ADDR_W(ADDR_W), .TMO(TMO)) dut (
    .clk_100m(clk_100m), .rst(rst),
    .m_req(m_req), .m_wr(m_wr),
    .m_addr0(m_addr0), .m_addr1(m_addr1),
    .m_bytes0(m_bytes0), .m_bytes1(m_bytes1),
    .m_gnt(m_gnt), .m_done(m_done), .m_err(m_err),
    .sdram_init_done(sdram_init_done),
    .sdram_rd_ack(sdram_rd_ack), .sdram_wr_ack(sdram_wr_ack),
    .sdram_rd_req(sdram_rd_req), .sdram_wr_req(sdram_wr_req),
    .sdram_addr(sdram_addr), .sdwr_bytes(sdwr_bytes), .sdrd_bytes(sdrd_bytes),
    .arb_busy(arb_busy)
  );

  always #5 clk_100m = ~clk_100m;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_gnt"},  32'(m_gnt), 0);
    check_eq({tag, "_done"}, 32'(m_done), 0);
    check_eq({tag, "_err"},  32'(m_err), 0);
    check_eq({tag, "_rdq"},  32'(sdram_rd_req), 0);
    check_eq({tag, "_wrq"},  32'(sdram_wr_req), 0);
    check_eq({tag, "_addr"}, 32'(sdram_addr), 0);
    check_eq({tag, "_wrb"},  32'(sdwr_bytes), 0);
    check_eq({tag, "_rdb"},  32'(sdrd_bytes), 0);
    check_eq({tag, "_busy"}, 32'(arb_busy), 0);
  endtask

  // Starts and ends at a falling edge with the arbiter idle and m_req=0.
  task automatic run_txn(input bit do_tmo, input bit ack_never);
    logic [1:0]        req, gbit;
    logic [ADDR_W-1:0] a0, a1, ea;
    logic [8:0]        b0, b1, eb;
    bit                win, wr, req_hi, mack;
    int                d, len, last_s;

    req = 2'($urandom_range(1, 3));
    a0 = ADDR_W'($urandom); a1 = ADDR_W'($urandom);
    b0 = 9'($urandom);      b1 = 9'($urandom);
    m_wr = 2'($urandom);
    win = (req == 2'b11) ? ~last_m : req[1];
    last_m = win;
    gbit = win ? 2'b10 : 2'b01;
    wr = m_wr[win];
    ea = win ? a1 : a0;
    eb = win ? b1 : b0;
    m_req = req; m_addr0 = a0; m_addr1 = a1; m_bytes0 = b0; m_bytes1 = b1;

    d = $urandom_range(0, 5);
    len = $urandom_range(1, 6);
    last_s = do_tmo ? TMO : d + len + 1;

    if ($urandom_range(0, 4) == 0) begin
      sdram_init_done = 1'b0;
      repeat ($urandom_range(1, 3)) begin
        @(negedge clk_100m);
        check_eq("noinit_gnt",  32'(m_gnt), 0);
        check_eq("noinit_rdq",  32'(sdram_rd_req), 0);
        check_eq("noinit_wrq",  32'(sdram_wr_req), 0);
        check_eq("noinit_busy", 32'(arb_busy), 0);
      end
      sdram_init_done = 1'b1;
    end

    for (int s = 0; s <= last_s + 1; s++) begin
      @(negedge clk_100m);
      req_hi = (s < last_s) && (ack_never || s <= d);
      check_eq("gnt",  32'(m_gnt), (s < last_s) ? 32'(gbit) : 0);
      check_eq("rdq",  32'(sdram_rd_req), 32'(req_hi && !wr));
      check_eq("wrq",  32'(sdram_wr_req), 32'(req_hi && wr));
      check_eq("done", 32'(m_done), (!do_tmo && s == last_s) ? 32'(gbit) : 0);
      check_eq("err",  32'(m_err),  (do_tmo && s == last_s) ? 32'(gbit) : 0);
      check_eq("busy", 32'(arb_busy), do_tmo ? 32'(s < last_s) : 32'(s <= last_s));
      check_eq("addr", 32'(sdram_addr), 32'(ea));
      check_eq("wrb",  32'(sdwr_bytes), wr ? 32'(eb) : 0);
      check_eq("rdb",  32'(sdrd_bytes), wr ? 0 : 32'(eb));

      mack = (s < last_s) && !ack_never && (s >= d) && (do_tmo || s < d + len);
      if (wr) begin
        sdram_wr_ack = mack;
        sdram_rd_ack = (s < last_s) && ($urandom_range(0, 4) == 0);
      end else begin
        sdram_rd_ack = mack;
        sdram_wr_ack = (s < last_s) && ($urandom_range(0, 4) == 0);
      end
      if (s == 0) begin
        m_req = 2'($urandom);
        m_wr = 2'($urandom);
        m_addr0 = ADDR_W'($urandom); m_addr1 = ADDR_W'($urandom);
        m_bytes0 = 9'($urandom);     m_bytes1 = 9'($urandom);
      end
      if (s > 0 && s < last_s) sdram_init_done = ($urandom_range(0, 7) != 0);
      if (s >= last_s) begin
        sdram_init_done = 1'b1;
        m_req = 2'b00;
      end
    end
  endtask

  initial begin
    int mode;
    rst = 1'b1;
    m_req = 2'b00; m_wr = 2'b00;
    m_addr0 = '0; m_addr1 = '0; m_bytes0 = 9'd0; m_bytes1 = 9'd0;
    sdram_init_done = 1'b1; sdram_rd_ack = 1'b0; sdram_wr_ack = 1'b0;
    #1;
    check_all_zero("rst");
    repeat (3) @(negedge clk_100m);
    rst = 1'b0;
    @(negedge clk_100m);
    check_all_zero("post_rst");

    for (int t = 0; t < 80; t++) begin
      mode = $urandom_range(0, 7);
      run_txn(mode < 2, mode == 0);
    end

    // write in flight on port0, stray read ack and input changes, then reset in XFER
    m_req = 2'b01; m_wr = 2'b01; m_addr0 = 22'h000123; m_bytes0 = 9'd16;
    sdram_init_done = 1'b1;
    @(negedge clk_100m);
    check_eq("dir_gnt", 32'(m_gnt), 32'h1);
    check_eq("dir_wrq", 32'(sdram_wr_req), 1);
    sdram_wr_ack = 1'b1;
    @(negedge clk_100m);
    check_eq("dir_xfer_wrq", 32'(sdram_wr_req), 0);
    sdram_rd_ack = 1'b1; m_addr0 = 22'h3FFFFF; m_wr = 2'b00;
    @(negedge clk_100m);
    check_eq("dir_hold_gnt",  32'(m_gnt), 32'h1);
    check_eq("dir_hold_rdq",  32'(sdram_rd_req), 0);
    check_eq("dir_hold_addr", 32'(sdram_addr), 32'h123);
    check_eq("dir_hold_wrb",  32'(sdwr_bytes), 16);
    check_eq("dir_hold_rdb",  32'(sdrd_bytes), 0);
    check_eq("dir_hold_busy", 32'(arb_busy), 1);
    check_eq("dir_hold_done", 32'(m_done), 0);
    sdram_rd_ack = 1'b0;
    rst = 1'b1;
    #1;
    check_all_zero("mid_rst");
    sdram_wr_ack = 1'b0;
    @(negedge clk_100m);
    check_all_zero("mid_rst_hold");
    rst = 1'b0;
    m_req = 2'b00;
    @(negedge clk_100m);
    check_all_zero("rst_release");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter: ADDR_W, 22, SDRAM address width (bank+row+col).
REQ-002 SHALL have parameter: TMO, 1000, max cycles allowed in ISSUE+XFER before timeout abort (16-bit).
REQ-003 SHALL have port: clk_100m  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port: m_req  input  2  per-port request; bit i = port i; requester holds it until m_done[i] or m_err[i].
REQ-006 SHALL have port: m_wr  input  2  per-port direction; 1 = write, 0 = read.
REQ-007 SHALL have ports: m_addr0, m_addr1  input  ADDR_W each  per-port start address.
REQ-008 SHALL have ports: m_bytes0, m_bytes1  input  9 each  per-port burst length.
REQ-009 SHALL have port: m_gnt  output  2  one-hot grant, or 0.
REQ-010 SHALL have port: m_done  output  2  one-cycle completion pulse to the granted port.
REQ-011 SHALL have port: m_err  output  2  one-cycle timeout pulse to the granted port.
REQ-012 SHALL have port: sdram_init_done  input  1  controller initialisation complete.
REQ-013 SHALL have ports: sdram_rd_ack, sdram_wr_ack  input  1 each  controller data-phase indicators; each is high for one or more cycles per transaction.
REQ-014 SHALL have ports: sdram_rd_req, sdram_wr_req  output  1 each  controller requests.
REQ-015 SHALL have ports: sdram_addr  output  ADDR_W; sdwr_bytes, sdrd_bytes  output  9 each.
REQ-016 SHALL have port: arb_busy  output  1  high whenever state != IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, XFER, DONE; all outputs SHALL be registered.
REQ-018 IDLE: if sdram_init_done=1 and m_req!=0, SHALL select a winner, latch its index, m_wr, address and bytes, set m_gnt one-hot, and go to ISSUE on the next edge.
REQ-019 Round-robin: last_port SHALL be a 1-bit register; a single requester SHALL win immediately; when both request, the winner SHALL be the port != last_port; last_port SHALL update to the winner on grant.
REQ-020 While sdram_init_done=0, the FSM SHALL remain in IDLE with m_gnt=0.
REQ-021 ISSUE: SHALL hold sdram_rd_req=1 (latched read) or sdram_wr_req=1 (latched write); on sampling the matching ack=1, SHALL deassert the request at that edge and go to XFER.
REQ-022 An ack of the non-matching type SHALL be ignored in every state.
REQ-023 XFER: on sampling the matching ack=0, SHALL go to DONE.
REQ-024 DONE: SHALL pulse m_done[port] for exactly one cycle, clear m_gnt, and go to IDLE; a new grant SHALL occur no earlier than the following IDLE cycle.
REQ-025 sdram_rd_req and sdram_wr_req SHALL never both be 1.
REQ-026 sdram_addr SHALL equal the latched address from ISSUE entry and SHALL hold its last value in IDLE.
REQ-027 sdwr_bytes SHALL equal latched bytes for a write, else 0; sdrd_bytes SHALL equal latched bytes for a read, else 0.
REQ-028 m_req, m_wr, m_addr and m_bytes changes after grant SHALL NOT affect the transaction in flight.
REQ-029 If the granted requester drops m_req mid-transaction, the transaction SHALL complete and m_done SHALL still pulse.
REQ-030 Timeout counter: cleared on ISSUE entry; incremented each cycle in ISSUE or XFER; saturating, no wrap.
REQ-031 On the counter reaching TMO: SHALL pulse m_err[port] for one cycle, deassert both sdram requests, clear m_gnt, go to IDLE, and SHALL NOT pulse m_done.
REQ-032 A sdram_init_done fall during ISSUE or XFER SHALL NOT abort the transaction; the timeout governs.

Reset
REQ-033 While rst=1: state=IDLE, m_gnt=0, m_done=0, m_err=0, sdram_rd_req=0, sdram_wr_req=0, sdram_addr=0, sdwr_bytes=0, sdrd_bytes=0, arb_busy=0, last_port=1, timeout counter=0.
REQ-034 Reset asserted mid-transaction SHALL abort immediately with no m_done or m_err pulse.

Verification
REQ-035 init_done=1; m_req=01, m_wr=00, m_addr0=0x000100, m_bytes0=8; ack asserted 3 cycles after rd_req for 8 cycles -> m_gnt=01; sdram_rd_req high until ack seen; sdrd_bytes=8, sdwr_bytes=0; m_done=01 for one cycle after ack falls.
REQ-036 Out of reset, m_req=11 held, both writes; each port acked after 2 cycles -> grant order port0, port1, port0, port1; sdram_wr_req only; m_done pulses alternate.
REQ-037 init_done=0, m_req=10 -> m_gnt=0 and no sdram request; raise init_done -> grant port1 the next IDLE cycle.
REQ-038 TMO=20; read request, ack never asserted -> m_err=granted bit pulses at cycle 20 of ISSUE; m_done=0; rd_req drops; FSM returns to IDLE.
REQ-039 Write in flight on port0; pulse sdram_rd_ack, and change m_addr0 and m_wr -> no state change, outputs unchanged; then rst=1 during XFER -> all outputs 0 at once, no m_done.
